// File: rtl/opp_state_tracker.sv
// Opponent state tracker: validates 44-bit words from the link, keeps the last
// accepted opponent position/direction/game state, and tracks link liveness.
module opp_state_tracker #(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int X_LIMIT        = 1024,
  parameter int Y_LIMIT        = 768,
  parameter int DIR_LIMIT      = 360
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        axiiv,
  input  logic [43:0] axiid,
  output logic [10:0] opp_x,
  output logic [10:0] opp_y,
  output logic [8:0]  opp_dir,
  output logic [2:0]  opp_game,
  output logic        opp_update,
  output logic        opp_rst_req,
  output logic        link_up,
  output logic [7:0]  err_count
);

  localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [11:0] X_LIM   = 12'(X_LIMIT);
  localparam logic [11:0] Y_LIM   = 12'(Y_LIMIT);
  localparam logic [9:0]  DIR_LIM = 10'(DIR_LIMIT);

  typedef enum logic {DOWN = 1'b0, UP = 1'b1} state_t;

  // Handshake: axiiv is a one-cycle strobe with no backpressure; every cycle
  // with axiiv=1 carries exactly one word, which is either accepted or rejected.

  state_t              state, state_nxt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [2:0]          last_seq;
  logic                rst_prev;
  logic                rst_fired;
  logic                armed;

  logic [10:0] w_x;
  logic [10:0] w_y;
  logic [8:0]  w_dir;
  logic [2:0]  w_seq;
  logic [2:0]  w_game;
  logic        w_rst;
  logic [2:0]  w_marker;
  logic        unused_bits;

  logic well_formed, seq_ok, accept, reject, timeout, rst_pair;

  assign w_x         = axiid[43:33];
  assign w_y         = axiid[31:21];
  assign w_dir       = axiid[19:11];
  assign w_seq       = axiid[10:8];
  assign w_game      = axiid[7:5];
  assign w_rst       = axiid[3];
  assign w_marker    = axiid[2:0];
  assign unused_bits = ^{axiid[32], axiid[20], axiid[4]};

  assign well_formed = axiiv && (w_marker == 3'b101) &&
                       ({1'b0, w_x} < X_LIM) && ({1'b0, w_y} < Y_LIM) &&
                       ({1'b0, w_dir} < DIR_LIM);
  assign seq_ok      = (state == DOWN) || (w_seq == 3'(last_seq + 3'd1));
  // armed is low for the first edge after reset release, so a word landing on
  // the deassertion edge is dropped silently rather than counted.
  assign accept      = armed && well_formed && seq_ok;
  assign reject      = armed && axiiv && !accept;
  assign timeout     = (state == UP) && !accept && (idle_cnt == IDLE_LAST);
  assign rst_pair    = accept && w_rst && rst_prev && !rst_fired;

  assign link_up     = (state == UP);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= DOWN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DOWN:    if (accept)  state_nxt = UP;
      UP:      if (timeout) state_nxt = DOWN;
      default: state_nxt = DOWN;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      opp_x       <= '0;
      opp_y       <= '0;
      opp_dir     <= '0;
      opp_game    <= '0;
      opp_update  <= 1'b0;
      opp_rst_req <= 1'b0;
      err_count   <= '0;
      last_seq    <= '0;
      idle_cnt    <= '0;
      rst_prev    <= 1'b0;
      rst_fired   <= 1'b0;
      armed       <= 1'b0;
    end else begin
      armed       <= 1'b1;
      opp_update  <= accept;
      opp_rst_req <= rst_pair;
      if (accept) begin
        opp_x    <= w_x;
        opp_y    <= w_y;
        opp_dir  <= w_dir;
        opp_game <= w_game;
        last_seq <= w_seq;
        rst_prev <= w_rst;
        if (!w_rst)        rst_fired <= 1'b0;
        else if (rst_pair) rst_fired <= 1'b1;
      end else if (timeout) begin
        rst_prev  <= 1'b0;
        rst_fired <= 1'b0;
      end
      if (reject && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
      if (accept || timeout || (state == DOWN)) idle_cnt <= '0;
      else                                      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

endmodule

// File: tb/tb_opp_state_tracker.sv
// Scoreboard bench for opp_state_tracker: directed words, expected updates
// queued at issue time and popped by an independent monitor on opp_update.
module tb_opp_state_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        axiiv = 1'b0;
  logic [43:0] axiid = '0;
  logic [10:0] opp_x, opp_y;
  logic [8:0]  opp_dir;
  logic [2:0]  opp_game;
  logic        opp_update, opp_rst_req, link_up;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [34:0] exp_q[$];
  logic [34:0] mon_e;

  opp_state_tracker #(.TIMEOUT_CYCLES(16)) dut (
    .clk_in(clk), .rst_in(rst), .axiiv(axiiv), .axiid(axiid),
    .opp_x(opp_x), .opp_y(opp_y), .opp_dir(opp_dir), .opp_game(opp_game),
    .opp_update(opp_update), .opp_rst_req(opp_rst_req),
    .link_up(link_up), .err_count(err_count)
  );

  // clock / watchdog
  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [43:0] mk(input int x, input int y, input int dir,
                                     input int seq, input int game, input int r,
                                     input int marker);
    logic [43:0] w;
    w = '0;
    w[43:33] = x[10:0];
    w[31:21] = y[10:0];
    w[19:11] = dir[8:0];
    w[10:8]  = seq[2:0];
    w[7:5]   = game[2:0];
    w[3]     = r[0];
    w[2:0]   = marker[2:0];
    return w;
  endfunction

  // driver: one word for one cycle, then one idle cycle
  task automatic send(input logic [43:0] w, input bit acc, input bit rr);
    @(negedge clk);
    axiiv = 1'b1;
    axiid = w;
    if (acc) exp_q.push_back({w[43:33], w[31:21], w[19:11], w[7:5], rr});
    @(negedge clk);
    axiiv = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && opp_update) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_update: got update x=%0d with no word expected", opp_x);
      end else begin
        mon_e = exp_q.pop_front();
        check("upd_x", opp_x, mon_e[34:24]);
        check("upd_y", opp_y, mon_e[23:13]);
        check("upd_dir", opp_dir, mon_e[12:4]);
        check("upd_game", opp_game, mon_e[3:1]);
        check("upd_rst_req", opp_rst_req, mon_e[0]);
      end
    end else if (!rst && opp_rst_req) begin
      n_checks++;
      n_errors++;
      $display("FAIL stray_rst_req: got 1 expected 0 without update");
    end
  end

  initial begin
    // reset with a valid word presented throughout
    axiiv = 1'b1;
    axiid = mk(100, 200, 90, 5, 1, 0, 5);
    repeat (3) @(negedge clk);
    check("rst_link", link_up, 0);
    check("rst_err", err_count, 0);
    check("rst_x", opp_x, 0);
    check("rst_update", opp_update, 0);
    check("rst_rst_req", opp_rst_req, 0);
    @(posedge clk);
    rst = 1'b0;
    @(negedge clk);
    axiiv = 1'b0;
    @(negedge clk);
    check("release_link", link_up, 0);
    check("release_err", err_count, 0);

    // first word after reset
    send(mk(100, 200, 90, 5, 1, 0, 5), 1, 0);
    check("first_link", link_up, 1);

    // sequence wrap 6,7,0 then a skipped seq
    send(mk(10, 20, 30, 6, 2, 0, 5), 1, 0);
    send(mk(11, 21, 31, 7, 3, 0, 5), 1, 0);
    send(mk(12, 22, 32, 0, 4, 0, 5), 1, 0);
    send(mk(13, 23, 33, 2, 5, 0, 5), 0, 0);
    check("badseq_err", err_count, 1);
    check("badseq_hold_x", opp_x, 12);
    check("badseq_hold_dir", opp_dir, 32);
    check("badseq_hold_game", opp_game, 4);

    // range limits: largest legal values accepted, first illegal rejected
    send(mk(1023, 767, 359, 1, 7, 0, 5), 1, 0);
    send(mk(1024, 5, 5, 2, 0, 0, 5), 0, 0);
    send(mk(5, 768, 5, 2, 0, 0, 5), 0, 0);
    send(mk(5, 5, 360, 2, 0, 0, 5), 0, 0);
    send(mk(5, 5, 5, 2, 0, 0, 0), 0, 0);
    check("range_err", err_count, 5);
    check("range_link", link_up, 1);

    // remote reset pairing, with a rejected word in between
    send(mk(20, 20, 20, 2, 0, 1, 5), 1, 0);
    send(mk(5, 5, 5, 3, 0, 0, 4), 0, 0);
    send(mk(21, 21, 21, 3, 0, 1, 5), 1, 1);
    send(mk(22, 22, 22, 4, 0, 1, 5), 1, 0);
    send(mk(23, 23, 23, 5, 0, 0, 5), 1, 0);
    send(mk(24, 24, 24, 6, 0, 1, 5), 1, 0);
    send(mk(77, 25, 25, 7, 6, 1, 5), 1, 1);
    check("pair_err", err_count, 6);

    // idle timeout: down exactly 16 edges after the last accepted word
    repeat (15) @(negedge clk);
    check("timeout_still_up", link_up, 1);
    @(negedge clk);
    check("timeout_down", link_up, 0);
    check("timeout_err_hold", err_count, 6);
    check("timeout_x_hold", opp_x, 77);
    check("timeout_game_hold", opp_game, 6);

    // relink with arbitrary seq; rst pairing restarted by the timeout
    send(mk(40, 50, 60, 3, 1, 1, 5), 1, 0);
    check("relink_up", link_up, 1);
    send(mk(41, 51, 61, 4, 1, 1, 5), 1, 1);

    // word accepted on the very cycle the timeout would fire
    repeat (14) @(negedge clk);
    send(mk(42, 52, 62, 5, 2, 0, 5), 1, 0);
    check("coincident_up", link_up, 1);
    repeat (15) @(negedge clk);
    check("coincident_still_up", link_up, 1);

    // error counter saturation
    for (int i = 0; i < 300; i++) send(mk(5, 5, 5, 0, 0, 0, 0), 0, 0);
    check("sat_err", err_count, 255);
    check("sat_link", link_up, 0);
    check("drain_before_reset", exp_q.size(), 0);

    // asynchronous reset mid-stream
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rerst_err", err_count, 0);
    send(mk(7, 8, 9, 0, 1, 0, 5), 1, 0);
    for (int i = 0; i < 3; i++) send(mk(7, 8, 9, 1, 1, 0, 0), 0, 0);
    check("pre_async_err", err_count, 3);
    check("pre_async_link", link_up, 1);
    check("drain_before_async", exp_q.size(), 0);
    @(negedge clk);
    axiiv = 1'b1;
    axiid = mk(60, 70, 80, 1, 6, 1, 5);
    @(posedge clk);
    #2;
    axiiv = 1'b0;
    check("pre_async_update", opp_update, 1);
    rst = 1'b1;
    #1;
    check("async_link", link_up, 0);
    check("async_err", err_count, 0);
    check("async_x", opp_x, 0);
    check("async_y", opp_y, 0);
    check("async_dir", opp_dir, 0);
    check("async_game", opp_game, 0);
    check("async_update", opp_update, 0);
    check("async_rst_req", opp_rst_req, 0);
    @(negedge clk);
    @(posedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("final_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/opp_state_tracker.md
OPP_STATE_TRACKER -- requirements
Module: opp_state_tracker

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2500000, idle cycles without an accepted word before the link is declared down.
REQ-002 Parameter X_LIMIT, default 1024, exclusive upper bound on x.
REQ-003 Parameter Y_LIMIT, default 768, exclusive upper bound on y.
REQ-004 Parameter DIR_LIMIT, default 360, exclusive upper bound on dir.
REQ-005 Port clk_in, input, 1, single clock for the whole block (eth_refclk domain, 50 MHz).
REQ-006 Port rst_in, input, 1, reset; asynchronous, active-high.
REQ-007 Port axiiv, input, 1, received-word valid strobe; one word per cycle when high.
REQ-008 Port axiid, input, 44, received word.
REQ-009 Port opp_x, output, 11, last accepted opponent x.
REQ-010 Port opp_y, output, 11, last accepted opponent y.
REQ-011 Port opp_dir, output, 9, last accepted opponent direction.
REQ-012 Port opp_game, output, 3, last accepted opponent game status.
REQ-013 Port opp_update, output, 1, one-cycle pulse when the opp_* fields are updated.
REQ-014 Port opp_rst_req, output, 1, one-cycle pulse on a confirmed remote reset request.
REQ-015 Port link_up, output, 1, high while the opponent link is alive.
REQ-016 Port err_count, output, 8, saturating count of rejected words.

Function
REQ-017 The word format shall be: x=[43:33], y=[31:21], dir=[19:11], seq=[10:8], game=[7:5], rst=[3], marker=[2:0]; bits 32, 20 and 4 are ignored.
REQ-018 A word is well-formed iff axiiv=1, marker=3'b101, x<X_LIMIT, y<Y_LIMIT and dir<DIR_LIMIT.
REQ-019 The state machine shall have two states: DOWN (reset state) and UP; link_up=1 exactly in UP.
REQ-020 In DOWN, a well-formed word shall be accepted regardless of seq, record seq as last_seq and transition to UP.
REQ-021 In UP, a well-formed word shall be accepted iff seq == last_seq+1 mod 8 (3-bit wrap, 7->0); on acceptance last_seq is updated.
REQ-022 A word with axiiv=1 that is not well-formed, or that is well-formed but has a bad seq in UP, shall be rejected: no field update, err_count+1, saturating at 255.
REQ-023 On acceptance, opp_x/opp_y/opp_dir/opp_game shall be registered with the word's fields, and opp_update shall pulse high on the cycle after the accepted axiiv (latency 1).
REQ-024 The idle counter shall clear on every accepted word and otherwise increment while in UP; when it reaches TIMEOUT_CYCLES-1 and no word is accepted that cycle, the state shall return to DOWN on the next edge.
REQ-025 Acceptance in the same cycle as the timeout condition shall win: the state remains UP and the counter clears.
REQ-026 On entering DOWN by timeout, the opp_* fields shall hold their last values, and err_count shall be unchanged.
REQ-027 opp_rst_req shall pulse for one cycle, coincident with opp_update, when the accepted word has rst=1 and the previous accepted word also had rst=1 (two consecutive accepted words); a third consecutive rst word shall not pulse again until an accepted word with rst=0 is seen.
REQ-028 Rejected words shall not break or count toward the rst=1 consecutive-pair tracking; a timeout shall clear it.
REQ-029 With axiiv=0, no outputs other than link_up shall change, and link_up changes only by timeout.

Reset
REQ-030 While rst_in=1, the block shall hold: state DOWN, link_up=0, opp_x=0, opp_y=0, opp_dir=0, opp_game=0, opp_update=0, opp_rst_req=0, err_count=0, last_seq=0, idle counter=0, rst tracking cleared.
REQ-031 A word presented with axiiv=1 while rst_in is asserted, or on the same edge as deassertion, shall be discarded without counting as an error.

Verification
REQ-032 After reset, word x=100,y=200,dir=90,seq=5,game=1,marker=101 -> next cycle opp_update=1, opp_x=100, opp_y=200, opp_dir=90, link_up=1.
REQ-033 Accepted words with seq 6,7,0 then a word with seq 2 -> seq 7->0 wrap accepted; the seq=2 word is rejected, err_count=1, fields hold the seq=0 values.
REQ-034 Words with x=1024, dir=360, marker=3'b000 each -> all rejected; 300 such words -> err_count=255 (saturated).
REQ-035 TIMEOUT_CYCLES=16, one accepted word, then idle -> link_up falls 16 cycles after that word; next accepted word with any seq -> link_up=1.
REQ-036 Three consecutive accepted words with rst=1 -> opp_rst_req pulses once, on the second word's opp_update; then rst=0, rst=1, rst=1 -> one more pulse.
REQ-037 Assert rst_in mid-stream while in UP with err_count=3 -> all outputs return to the REQ-030 values asynchronously, without waiting for a clk_in edge.
